amba_regbank: RTL and testbench

Parametrised memory-mapped register bank on the TPU's AMBA-style valid/ready configuration bus. It generalises the fixed five-register write decoder into a configurable bank with:
- a full read/write handshake;
- error responses for unmapped addresses;
- a sticky write-1-to-clear interrupt status register.

It sits between the bus master and the TPU control/TX/RX datapath. It drives the register contents as flat outputs.

---
 rtl/amba_regbank.sv | 136 +++++++++++++
 tb/tb_amba_regbank.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/amba_regbank.sv
`default_nettype none
// ============================================================================
// Module      : amba_regbank
// Description : Parametrised valid/ready register bank with an error response
//               for unmapped addresses and a sticky W1C interrupt status.
// Revision    : 1.0 - initial release
// ============================================================================
module amba_regbank #(
    parameter int                DATA_W    = 8,
    parameter int                ADDR_W    = 8,
    parameter logic [ADDR_W-1:0] BASE_ADDR = 'h20,
    parameter int                NUM_REGS  = 5,
    parameter int                CTRL_W    = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       valid,
    input  logic                       write,
    input  logic [ADDR_W-1:0]          addr,
    input  logic [DATA_W-1:0]          wdata,
    output logic                       ready,
    output logic [DATA_W-1:0]          rdata,
    output logic                       err,
    output logic [NUM_REGS*DATA_W-1:0] regs_flat,
    input  logic [DATA_W-1:0]          irq_set,
    output logic                       irq
);

    localparam int                C_LAST      = NUM_REGS - 1;
    localparam logic [ADDR_W:0]   C_NUM       = (ADDR_W+1)'(NUM_REGS);
    localparam logic [DATA_W-1:0] C_CTRL_MASK = DATA_W'((2 ** CTRL_W) - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RESP = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic                ready_q, ready_d;
    logic                err_q,   err_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic [DATA_W-1:0]   regs_q [NUM_REGS];
    logic [DATA_W-1:0]   regs_d [NUM_REGS];

    logic [ADDR_W-1:0]   w_off;
    logic                w_mapped;
    logic                w_wr;
    logic [NUM_REGS-1:0] w_sel;
    logic [DATA_W-1:0]   w_rd;
    logic [DATA_W-1:0]   w_clr;

    // Offset is taken at ADDR_W width; addresses below the base never wrap in.
    assign w_off    = addr - BASE_ADDR;
    assign w_mapped = (addr >= BASE_ADDR) && ({1'b0, w_off} < C_NUM);
    assign w_wr     = (state_q == S_IDLE) && valid && write && w_mapped;

    always_comb begin
        w_sel = '0;
        w_rd  = '0;
        for (int k = 0; k < NUM_REGS; k++) begin
            if ({1'b0, w_off} == (ADDR_W+1)'(k)) begin
                w_sel[k] = 1'b1;
                w_rd     = regs_q[k];
            end
        end
    end

    assign w_clr = (w_wr && w_sel[C_LAST]) ? wdata : '0;

    always_comb begin
        for (int k = 0; k < NUM_REGS; k++) begin
            regs_d[k] = regs_q[k];
            if (w_wr && w_sel[k]) begin
                regs_d[k] = (k == 0) ? (wdata & C_CTRL_MASK) : wdata;
            end
        end
        // Set pulses are ORed in after the clear so a same-cycle set survives.
        regs_d[C_LAST] = (regs_q[C_LAST] & ~w_clr) | irq_set;
    end

    always_comb begin
        state_d = state_q;
        ready_d = 1'b0;
        rdata_d = '0;
        err_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (valid) begin
                    state_d = S_RESP;
                    ready_d = 1'b1;
                    err_d   = !w_mapped;
                    if (!write && w_mapped) begin
                        rdata_d = w_rd;
                    end
                end
            end
            S_RESP:  state_d = S_HOLD;
            S_HOLD:  if (!valid) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            ready_q <= 1'b0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            for (int k = 0; k < NUM_REGS; k++) begin
                regs_q[k] <= '0;
            end
        end else begin
            state_q <= state_d;
            ready_q <= ready_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            for (int k = 0; k < NUM_REGS; k++) begin
                regs_q[k] <= regs_d[k];
            end
        end
    end

    generate
        for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
            assign regs_flat[g*DATA_W +: DATA_W] = regs_q[g];
        end
    endgenerate

    assign ready = ready_q;
    assign rdata = rdata_q;
    assign err   = err_q;
    assign irq   = |regs_q[C_LAST];

endmodule
`default_nettype wire

// File: tb/tb_amba_regbank.sv
`default_nettype none
// ============================================================================
// Module      : tb_amba_regbank
// Description : Directed scoreboard bench for amba_regbank.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_amba_regbank;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid;
    logic        write;
    logic [7:0]  addr;
    logic [7:0]  wdata;
    logic        ready;
    logic [7:0]  rdata;
    logic        err;
    logic [39:0] regs_flat;
    logic [7:0]  irq_set;
    logic        irq;

    int total = 0;
    int bad   = 0;
    logic [8:0] sb[$];

    amba_regbank dut (
        .clk       (clk),
        .rst       (rst),
        .valid     (valid),
        .write     (write),
        .addr      (addr),
        .wdata     (wdata),
        .ready     (ready),
        .rdata     (rdata),
        .err       (err),
        .regs_flat (regs_flat),
        .irq_set   (irq_set),
        .irq       (irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One transaction: expected {err, rdata} pushed at drive time, popped at ready.
    task automatic xact(input logic w, input logic [7:0] a, input logic [7:0] d,
                        input logic [7:0] exp_rd, input logic exp_err,
                        input logic [7:0] irqv);
        logic       got;
        logic [8:0] e;
        sb.push_back({exp_err, exp_rd});
        @(negedge clk);
        valid = 1'b1; write = w; addr = a; wdata = d; irq_set = irqv;
        got = 1'b0;
        for (int i = 0; i < 8 && !got; i++) begin
            @(negedge clk);
            irq_set = 8'h00;
            if (ready) begin
                got = 1'b1;
                chk("latency", 64'(i), 64'd0);
                e = sb.pop_front();
                chk("rdata", {56'd0, rdata}, {56'd0, e[7:0]});
                chk("err", {63'd0, err}, {63'd0, e[8]});
            end
        end
        if (!got) chk("ready_timeout", 64'd0, 64'd1);
        valid = 1'b0;
        @(negedge clk);
        chk("post_ready", {55'd0, ready, rdata}, 64'd0);
        chk("post_err", {63'd0, err}, 64'd0);
    endtask

    initial begin
        int pulses;
        logic [8:0] e;
        rst = 1'b1; valid = 1'b0; write = 1'b0; addr = '0; wdata = '0; irq_set = '0;
        repeat (3) @(negedge clk);
        chk("rst_outs", {54'd0, ready, err, irq, rdata}, 64'd0);
        chk("rst_regs", {24'd0, regs_flat}, 64'd0);
        rst = 1'b0;

        xact(1'b1, 8'h20, 8'hFF, 8'h00, 1'b0, 8'h00);
        chk("ctrl_mask", {56'd0, regs_flat[7:0]}, 64'h0F);
        xact(1'b0, 8'h20, 8'h00, 8'h0F, 1'b0, 8'h00);

        xact(1'b1, 8'h21, 8'hA5, 8'h00, 1'b0, 8'h00);
        xact(1'b1, 8'h22, 8'h3C, 8'h00, 1'b0, 8'h00);
        xact(1'b0, 8'h21, 8'h00, 8'hA5, 1'b0, 8'h00);
        xact(1'b0, 8'h22, 8'h00, 8'h3C, 1'b0, 8'h00);
        chk("regs_rw", {24'd0, regs_flat}, 64'h00_00_3C_A5_0F);

        // Interrupt set then piecewise W1C clear
        @(negedge clk); irq_set = 8'h81;
        @(negedge clk); irq_set = 8'h00;
        chk("irq_set", {63'd0, irq}, 64'd1);
        chk("stat_81", {56'd0, regs_flat[39:32]}, 64'h81);
        xact(1'b1, 8'h24, 8'h01, 8'h00, 1'b0, 8'h00);
        chk("stat_80", {56'd0, regs_flat[39:32]}, 64'h80);
        chk("irq_still", {63'd0, irq}, 64'd1);
        xact(1'b1, 8'h24, 8'h80, 8'h00, 1'b0, 8'h00);
        chk("irq_clear", {63'd0, irq}, 64'd0);

        // Set and clear of bit 0 on the same edge: set wins
        @(negedge clk); irq_set = 8'h01;
        @(negedge clk); irq_set = 8'h00;
        xact(1'b1, 8'h24, 8'h01, 8'h00, 1'b0, 8'h01);
        chk("set_wins", {56'd0, regs_flat[39:32]}, 64'h01);
        xact(1'b0, 8'h24, 8'h00, 8'h01, 1'b0, 8'h00);
        xact(1'b1, 8'h24, 8'h01, 8'h00, 1'b0, 8'h00);
        chk("stat_zero", {56'd0, regs_flat[39:32]}, 64'h00);

        xact(1'b1, 8'h1F, 8'h55, 8'h00, 1'b1, 8'h00);
        chk("unmapped_wr", {24'd0, regs_flat}, 64'h00_00_3C_A5_0F);
        xact(1'b0, 8'h25, 8'h00, 8'h00, 1'b1, 8'h00);

        // Held request: one W1C commit only; a later set of the same bit must stick
        sb.push_back({1'b0, 8'h00});
        pulses = 0;
        @(negedge clk);
        valid = 1'b1; write = 1'b1; addr = 8'h24; wdata = 8'h02;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            irq_set = (i == 1) ? 8'h02 : 8'h00;
            if (ready) begin
                pulses++;
                e = sb.pop_front();
                chk("hold_err", {63'd0, err}, {63'd0, e[8]});
            end
        end
        irq_set = 8'h00;
        chk("hold_pulses", 64'(pulses), 64'd1);
        chk("hold_commit", {56'd0, regs_flat[39:32]}, 64'h02);
        valid = 1'b0;
        @(negedge clk);
        xact(1'b0, 8'h21, 8'h00, 8'hA5, 1'b0, 8'h00);

        // Reset coinciding with an accepted write
        @(negedge clk);
        valid = 1'b1; write = 1'b1; addr = 8'h21; wdata = 8'h77; rst = 1'b1;
        @(negedge clk);
        chk("rst_mid_outs", {54'd0, ready, err, irq, rdata}, 64'd0);
        chk("rst_mid_regs", {24'd0, regs_flat}, 64'd0);
        valid = 1'b0; rst = 1'b0;
        @(negedge clk);
        chk("rst_no_ready", {63'd0, ready}, 64'd0);
        xact(1'b0, 8'h21, 8'h00, 8'h00, 1'b0, 8'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        bad++;
        $display("FAIL global_timeout observed=running expected=finished");
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
